// File: rtl/core_clock_sequencer.sv
// Run-control for the JZJCoreF devboard: debounced mode/step buttons select a
// full-rate, slow or halted core clock, with single-step and a rising-edge counter.

module core_clock_sequencer_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic press_o
);
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d, level_prev_q, press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) level_d = ~level_q;
      else                   cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], raw_i};
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press_o = press_q;
endmodule

module core_clock_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SLOW_DIV_LOG2   = 18
) (
  input  logic        clock,
  input  logic        notReset,
  input  logic        modeButton,
  input  logic        stepButton,
  output logic        coreClock,
  output logic [1:0]  mode,
  output logic [15:0] stepCount
);
  typedef enum logic [1:0] {
    S_HALT = 2'b00,
    S_FAST = 2'b01,
    S_SLOW = 2'b10,
    S_STEP = 2'b11
  } state_e;

  function automatic state_e next_mode(input state_e s);
    case (s)
      S_HALT:  return S_FAST;
      S_FAST:  return S_SLOW;
      S_SLOW:  return S_HALT;
      default: return S_FAST;
    endcase
  endfunction

  logic mode_press, step_press;

  core_clock_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk_i   (clock),
    .rst_ni  (notReset),
    .raw_i   (modeButton),
    .press_o (mode_press)
  );

  core_clock_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk_i   (clock),
    .rst_ni  (notReset),
    .raw_i   (stepButton),
    .press_o (step_press)
  );

  state_e                   state_q, state_d;
  logic                     clk_q, clk_d, clk_prev_q;
  logic                     pend_q, pend_d;
  logic [SLOW_DIV_LOG2-1:0] div_q, div_d;
  logic [15:0]              count_q;
  logic                     mode_req, nat_clk;

  always_comb begin
    mode_req = pend_q | mode_press;
    case (state_q)
      S_FAST:  nat_clk = ~clk_q;
      S_SLOW:  nat_clk = (div_q == '1) ? ~clk_q : clk_q;
      default: nat_clk = 1'b0;
    endcase

    state_d = state_q;
    clk_d   = nat_clk;
    pend_d  = pend_q;
    div_d   = '0;
    // A mode change only lands while the clock is low or about to fall,
    // so no high phase is ever cut short.
    if (mode_req && (!clk_q || !nat_clk)) begin
      state_d = next_mode(state_q);
      clk_d   = 1'b0;
      pend_d  = 1'b0;
    end else begin
      if (mode_req) pend_d = 1'b1;
      case (state_q)
        S_HALT: begin
          if (step_press) begin
            state_d = S_STEP;
            clk_d   = 1'b1;
          end
        end
        S_SLOW:  div_d   = div_q + 1'b1;
        S_STEP:  state_d = S_HALT;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!notReset) begin
      state_q    <= S_HALT;
      clk_q      <= 1'b0;
      clk_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      div_q      <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      clk_q      <= clk_d;
      clk_prev_q <= clk_q;
      pend_q     <= pend_d;
      div_q      <= div_d;
      if (clk_q && !clk_prev_q) count_q <= count_q + 16'd1;
    end
  end

  assign coreClock = clk_q;
  assign mode      = state_q;
  assign stepCount = count_q;
endmodule

// File: tb/tb_core_clock_sequencer.sv
// Bench for core_clock_sequencer: directed corner sequences, a vector table and a
// randomized run against a time-based reference model (DEBOUNCE_CYCLES=4, SLOW_DIV_LOG2=2).

module tb_core_clock_sequencer;
  localparam int D = 4;
  localparam int L = 2;
  localparam int N = 2000;

  logic        clock, notReset, modeButton, stepButton;
  logic        coreClock;
  logic [1:0]  mode;
  logic [15:0] stepCount;

  int total = 0;
  int bad   = 0;

  core_clock_sequencer #(.DEBOUNCE_CYCLES(D), .SLOW_DIV_LOG2(L)) dut (
    .clock      (clock),
    .notReset   (notReset),
    .modeButton (modeButton),
    .stepButton (stepButton),
    .coreClock  (coreClock),
    .mode       (mode),
    .stepCount  (stepCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive_btn(input bit which, input logic v);
    if (which) stepButton = v;
    else       modeButton = v;
  endtask

  task automatic do_reset();
    notReset = 1'b0;
    tick();
    tick();
    check("rst_clk", 32'(coreClock), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_cnt", 32'(stepCount), 0);
    notReset = 1'b1;
  endtask

  task automatic press(input bit which, input int hold, input int gap);
    drive_btn(which, 1'b1);
    for (int i = 0; i < hold; i++) tick();
    drive_btn(which, 1'b0);
    for (int i = 0; i < gap; i++) tick();
  endtask

  // Reference model state for the randomized run
  bit rm[N], rs[N], rosem[N], roses[N], clkh[N];

  function automatic bit raw_of(input bit which, input int idx);
    if (idx < 0) return 1'b0;
    return which ? rs[idx] : rm[idx];
  endfunction

  // Level accepted at edge k once the input seen by the synchronizer output
  // has held the opposite value for the last D edges.
  function automatic bit window_all(input bit which, input int k, input bit v);
    for (int j = k - D + 1; j <= k; j++)
      if (raw_of(which, j - 2) != v) return 1'b0;
    return 1'b1;
  endfunction

  typedef struct {
    bit btn;
    int hold;
    int exp_mode;
    int exp_cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int  saw;
    int  mmode, E, mcnt, rbad;
    bit  mclk, pend, lvm, lvs, mp, sp, prev, req, nom;

    notReset   = 1'b0;
    modeButton = 1'b0;
    stepButton = 1'b0;

    vecs[0] = '{1'b1, 6, 0, 1};
    vecs[1] = '{1'b1, 3, 0, 1};
    vecs[2] = '{1'b1, 4, 0, 2};
    vecs[3] = '{1'b0, 3, 0, 2};
    vecs[4] = '{1'b1, 10, 0, 3};
    vecs[5] = '{1'b0, 4, 1, -1};
    vecs[6] = '{1'b0, 5, 2, -1};
    vecs[7] = '{1'b1, 6, 2, -1};
    vecs[8] = '{1'b0, 6, 0, -1};
    vecs[9] = '{1'b1, 6, 0, -1};

    // Reset and idle HALT
    do_reset();
    saw = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (coreClock !== 1'b0) saw = 1;
    end
    check("reset_hold_low", 32'(saw), 0);

    // Single step
    stepButton = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("step_clk_e%0d", k), 32'(coreClock), (k == 7) ? 1 : 0);
    end
    stepButton = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("step_mode", 32'(mode), 0);
    check("step_cnt", 32'(stepCount), 1);

    // Bounce rejection then a clean hold
    saw = 0;
    for (int r = 0; r < 10; r++) begin
      modeButton = 1'b1;
      for (int i = 0; i < 3; i++) begin tick(); if (mode !== 2'b00) saw = 1; end
      modeButton = 1'b0;
      tick();
      if (mode !== 2'b00) saw = 1;
    end
    check("bounce_mode", 32'(saw), 0);
    modeButton = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 5) modeButton = 1'b0;
      if (k == 6) check("hold_mode_e6", 32'(mode), 0);
      if (k == 7) check("hold_mode_e7", 32'(mode), 1);
    end
    for (int i = 0; i < 8; i++) tick();

    // FAST -> SLOW with the press landing on a high phase
    saw = 0;
    for (int i = 0; i < 4 && coreClock !== 1'b0; i++) tick();
    check("fast_find_low", 32'(coreClock), 0);
    modeButton = 1'b1;
    for (int r = 0; r < 16; r++) begin
      tick();
      if (r == 5) modeButton = 1'b0;
      if (r >= 6)
        check($sformatf("f2s_clk_e%0d", r), 32'(coreClock),
              (r == 6 || (r >= 11 && r <= 14)) ? 1 : 0);
      if (r == 6) check("f2s_mode_e6", 32'(mode), 1);
      if (r == 7) check("f2s_mode_e7", 32'(mode), 2);
    end
    press(1'b0, 6, 20);
    check("s2h_mode", 32'(mode), 0);
    check("s2h_clk", 32'(coreClock), 0);

    // Simultaneous mode and step: mode wins
    do_reset();
    modeButton = 1'b1;
    stepButton = 1'b1;
    for (int r = 0; r < 10; r++) begin
      tick();
      if (r == 5) begin modeButton = 1'b0; stepButton = 1'b0; end
      if (r == 7) begin
        check("sim_mode", 32'(mode), 1);
        check("sim_clk_e7", 32'(coreClock), 0);
        check("sim_cnt_e7", 32'(stepCount), 0);
      end
      if (r == 8) check("sim_cnt_e8", 32'(stepCount), 0);
      if (r == 9) check("sim_cnt_e9", 32'(stepCount), 1);
    end

    // Mode press pending during STEP goes to FAST
    do_reset();
    stepButton = 1'b1;
    tick();
    modeButton = 1'b1;
    for (int r = 1; r < 11; r++) begin
      tick();
      if (r == 5) stepButton = 1'b0;
      if (r == 6) modeButton = 1'b0;
      if (r == 7) begin
        check("stp_mode_e7", 32'(mode), 3);
        check("stp_clk_e7", 32'(coreClock), 1);
      end
      if (r == 8) begin
        check("stp_mode_e8", 32'(mode), 1);
        check("stp_clk_e8", 32'(coreClock), 0);
        check("stp_cnt_e8", 32'(stepCount), 1);
      end
      if (r == 9)  check("stp_clk_e9", 32'(coreClock), 1);
      if (r == 10) check("stp_cnt_e10", 32'(stepCount), 2);
    end

    // Vector table
    do_reset();
    for (int v = 0; v < 10; v++) begin
      press(vecs[v].btn, vecs[v].hold, 14);
      check($sformatf("vec%0d_mode", v), 32'(mode), 32'(vecs[v].exp_mode));
      if (vecs[v].exp_mode == 0)
        check($sformatf("vec%0d_clk", v), 32'(coreClock), 0);
      if (vecs[v].exp_cnt >= 0)
        check($sformatf("vec%0d_cnt", v), 32'(stepCount), 32'(vecs[v].exp_cnt));
    end

    // Randomized run against the reference model
    for (int b = 0; b < 2; b++) begin
      int  t = 0;
      bit  lv = 1'b0;
      while (t < N) begin
        int len;
        if (lv) len = $urandom_range(1, 10);
        else    len = (b == 1) ? $urandom_range(1, 16) : $urandom_range(1, 40);
        for (int i = 0; i < len && t < N; i++) begin
          if (b == 1) rs[t] = lv;
          else        rm[t] = lv;
          t++;
        end
        lv = ~lv;
      end
    end
    do_reset();
    mmode = 0; E = 0; mcnt = 0; rbad = 0;
    mclk = 0; pend = 0; lvm = 0; lvs = 0;
    for (int t = 0; t < N; t++) begin
      modeButton = rm[t];
      stepButton = rs[t];
      tick();
      rosem[t] = 1'b0;
      if (window_all(1'b0, t, !lvm)) begin lvm = !lvm; rosem[t] = lvm; end
      roses[t] = 1'b0;
      if (window_all(1'b1, t, !lvs)) begin lvs = !lvs; roses[t] = lvs; end
      mp   = (t >= 2) ? rosem[t-2] : 1'b0;
      sp   = (t >= 2) ? roses[t-2] : 1'b0;
      prev = mclk;
      req  = mp | pend;
      case (mmode)
        3: begin
          mclk = 1'b0; pend = 1'b0;
          if (req) begin mmode = 1; E = t; end
          else mmode = 0;
        end
        0: begin
          if (req) begin mmode = 1; E = t; mclk = 1'b0; pend = 1'b0; end
          else if (sp) begin mmode = 3; mclk = 1'b1; end
        end
        default: begin
          nom = 1'(((t - E) >> ((mmode == 2) ? L : 0)) & 1);
          if (req && (!prev || !nom)) begin
            mmode = (mmode == 1) ? 2 : 0;
            E = t; mclk = 1'b0; pend = 1'b0;
          end else begin
            mclk = nom;
            if (req) pend = 1'b1;
          end
        end
      endcase
      clkh[t] = mclk;
      if (t >= 1 && clkh[t-1] && !((t >= 2) ? clkh[t-2] : 1'b0)) mcnt = (mcnt + 1) & 32'hFFFF;
      total++;
      if (coreClock !== mclk || mode !== 2'(mmode) || stepCount !== 16'(mcnt)) begin
        bad++;
        rbad++;
        $display("FAIL rand_t%0d: got clk=%0b mode=%0d cnt=%0d expected clk=%0b mode=%0d cnt=%0d",
                 t, coreClock, mode, stepCount, mclk, mmode, mcnt);
      end
      if (rbad >= 10) break;
    end
    modeButton = 1'b0;
    stepButton = 1'b0;

    // Counter wrap via FAST, then reset mid SLOW high phase
    do_reset();
    modeButton = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tick();
      if (r == 5) modeButton = 1'b0;
    end
    check("wrap_mode", 32'(mode), 1);
    check("wrap_cnt0", 32'(stepCount), 0);
    for (int i = 0; i < 131070; i++) tick();
    check("wrap_ffff", 32'(stepCount), 32'hFFFF);
    tick();
    tick();
    check("wrap_zero", 32'(stepCount), 0);
    modeButton = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tick();
      if (r == 5) modeButton = 1'b0;
    end
    check("mid_slow_mode", 32'(mode), 2);
    for (int i = 0; i < 10 && coreClock !== 1'b1; i++) tick();
    check("mid_slow_high", 32'(coreClock), 1);
    tick();
    notReset   = 1'b0;
    modeButton = 1'b1;
    tick();
    check("midrst_clk", 32'(coreClock), 0);
    check("midrst_mode", 32'(mode), 0);
    check("midrst_cnt", 32'(stepCount), 0);
    tick();
    notReset = 1'b1;
    saw = 0;
    for (int r = 0; r < 8; r++) begin
      tick();
      if (r < 7 && mode !== 2'b00) saw = 1;
      if (r == 7) check("held_mode_e7", 32'(mode), 1);
    end
    check("held_early", 32'(saw), 0);
    modeButton = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
